mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single-port memory interface (mem_addr/mem_rd_data/mem_wr_data/mem_wr_ena/mem_access/mem_exception)
//  among NUM_REQ requesters, e.g. multicycle core (port 0) plus debug/DMA master (port 1).
//  Round-robin arbitration with a valid/ready request and a one-cycle response pulse.
//  Sits between the cores and the MMU/memory map.
// PARAMETERS
//  NUM_REQ  2  number of requesters, legal 2..4; index 0 wins the first arbitration after reset
// PORTS
//  clk            in   1               clock; all state on posedge
//  rst            in   1               asynchronous, active-high reset
//  req_valid      in   NUM_REQ         request pending; hold fields stable until accepted
//  req_addr       in   NUM_REQ x 32    byte address
//  req_wr_data    in   NUM_REQ x 32    store data
//  req_wr_ena     in   NUM_REQ         1 = store, 0 = load
//  req_access     in   NUM_REQ x mem_access_t   access size
//  req_lock       in   NUM_REQ         bus-lock request (used only with ARB_BUS_LOCK_EN)
//  req_ready      out  NUM_REQ         one-hot; request accepted this cycle (valid & ready)
//  resp_valid     out  NUM_REQ         one-hot, one-cycle pulse; response for that requester
//  resp_rd_data   out  32              load data, valid when any resp_valid is high
//  resp_exception out  mem_exception_mask_t   exception mask, valid with resp_valid
//  mem_addr, mem_wr_data  out  32      memory address and store data
//  mem_wr_ena     out  1               memory write strobe
//  mem_access     out  mem_access_t    memory access size
//  mem_rd_data    in   32              memory read data; synchronous read, valid the cycle after the address
//  mem_exception  in   mem_exception_mask_t   memory exception, timed like mem_rd_data
// BEHAVIOUR
//  States: S_IDLE -> S_ACCESS -> S_RESPOND -> (S_ACCESS | S_IDLE).
//  Reset values: state S_IDLE; last_grant = NUM_REQ-1; hold registers 0.
//    All req_ready/resp_valid 0; mem_wr_ena 0; mem_addr 0; mem_access MEM_ACCESS_WORD.
//  S_IDLE / S_RESPOND arbitration:
//    - Winner = first asserted req_valid scanning from last_grant+1 (mod NUM_REQ).
//    - req_ready[winner] is combinational.
//    - On acceptance: latch addr/wr_data/wr_ena/access/index into hold registers, last_grant <= winner,
//      next state S_ACCESS. No valid request: S_IDLE.
//  S_ACCESS: drive mem_* from hold registers; mem_wr_ena = held wr_ena for exactly this cycle.
//  S_RESPOND:
//    - mem_addr/mem_access still driven from hold; mem_wr_ena 0.
//    - resp_valid[held index] = 1; resp_rd_data = mem_rd_data; resp_exception = mem_exception (stores too).
//    - A new acceptance in the same cycle is allowed.
//  Latency: accept at cycle t -> resp_valid at t+2. Peak throughput: one access per 2 cycles.
//  Fairness: no requester waits more than NUM_REQ-1 grants while asserting req_valid.
//  Outside S_ACCESS/S_RESPOND, mem_* show idle values; resp_rd_data = 0 when no resp_valid.
//  Boundaries:
//    - All requesters valid: strict rotation. A requester that just received resp may not win again
//      if another is valid. A single requester may be re-granted back-to-back.
//    - req_valid dropped before acceptance: legal; request is withdrawn.
//    - Reset mid-access: abandon immediately, no resp_valid. A store already in S_ACCESS may have completed.
//    - Exception: passed through; the arbiter neither retries nor blocks.
// CONFIGURATION
//  ARB_BUS_LOCK_EN defined:
//    - Acceptance with req_lock[winner]=1 sets lock_owner = winner, locked = 1.
//    - While locked, only lock_owner can be granted.
//    - Lock clears on an accepted owner request with req_lock=0, or at an arbitration point where
//      req_lock[owner] is 0. Used for atomic read-modify-write.
//    - Reset clears the lock.
//  ARB_BUS_LOCK_EN undefined: req_lock ignored; lock_owner/locked logic absent.
// STRUCTURE
//  mem_arb_pkg (shared package):
//    - arb_state_t enum {S_IDLE, S_ACCESS, S_RESPOND}
//    - MEM_ARB_MAX_REQ = 4
//    - idle constants for mem_access / mem_addr
//  mem_access_t and mem_exception_mask_t come from memory_access.sv / memory_exceptions.sv.
//  Sub-module rr_priority_picker (combinational):
//    inputs req[NUM_REQ], last_grant, mask; outputs one-hot grant, grant_idx, any.
//  FSM, hold registers, lock logic and output muxing live in mem_bus_arbiter.
// TESTING
//  1. Reset, req_valid[0]=1 load 0x1000_0004, mem returns 0xDEADBEEF
//       -> req_ready[0] at t, mem_addr 0x1000_0004 at t+1, resp_valid[0] and data 0xDEADBEEF at t+2.
//  2. Both ports continuously valid with loads
//       -> grants 0,1,0,1; accepts every 2 cycles; resp_valid never for the wrong index.
//  3. Port 1 store 0x55 to 0x2000_0000
//       -> mem_wr_ena high exactly one cycle (S_ACCESS) with wr_data 0x55. resp_valid[1] follows.
//          Later port 0 load of the same address -> 0x55.
//  4. rst asserted asynchronously during S_ACCESS of a port 0 load
//       -> outputs at reset values immediately; no resp_valid; next grant goes to port 0.
//  5. mem_exception nonzero on an access to an unmapped address
//       -> resp_exception equals the mask in the resp_valid cycle; the next request is served normally.
//  6. ARB_BUS_LOCK_EN: port 0 load with lock=1, then store with lock=0, port 1 valid throughout
//       -> port 1 not granted until port 0's store is accepted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory bus arbiter slice.
//   - mem_access_t / mem_exception_mask_t : stand-ins for the definitions in
//     memory_access.sv / memory_exceptions.sv, so this slice builds on its own.
//   - arb_state_t                          : arbiter FSM states.
//   - MEM_ARB_MAX_REQ                      : upper bound on requester count.
//   - MEM_*_IDLE                           : values driven on the memory port
//                                            when no access is in flight.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2
  } mem_access_t;

  typedef logic [3:0] mem_exception_mask_t;

  localparam mem_exception_mask_t MEM_EXC_NONE         = 4'b0000;
  localparam mem_exception_mask_t MEM_EXC_ACCESS_FAULT = 4'b0010;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } arb_state_t;

  localparam int          MEM_ARB_MAX_REQ = 4;
  localparam logic [31:0] MEM_ADDR_IDLE   = 32'h0000_0000;
  localparam logic [31:0] MEM_DATA_IDLE   = 32'h0000_0000;
  localparam mem_access_t MEM_ACCESS_IDLE = MEM_ACCESS_WORD;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles the requester-side handshake and the shared single-port memory bus.
//   Requester side : req_valid/addr/wr_data/wr_ena/access/lock in,
//                    req_ready, resp_valid, resp_rd_data, resp_exception out.
//   Memory side    : mem_addr/wr_data/wr_ena/access out,
//                    mem_rd_data, mem_exception in (one cycle after address).
// Modports:
//   slave  - the arbiter's view
//   master - the view of the environment (requesters + memory)
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic                [NUM_REQ-1:0]       req_valid;
  logic                [NUM_REQ-1:0][31:0] req_addr;
  logic                [NUM_REQ-1:0][31:0] req_wr_data;
  logic                [NUM_REQ-1:0]       req_wr_ena;
  mem_access_t         [NUM_REQ-1:0]       req_access;
  logic                [NUM_REQ-1:0]       req_lock;
  logic                [NUM_REQ-1:0]       req_ready;
  logic                [NUM_REQ-1:0]       resp_valid;
  logic                [31:0]              resp_rd_data;
  mem_exception_mask_t                     resp_exception;

  logic                [31:0]              mem_addr;
  logic                [31:0]              mem_wr_data;
  logic                                    mem_wr_ena;
  mem_access_t                             mem_access;
  logic                [31:0]              mem_rd_data;
  mem_exception_mask_t                     mem_exception;

  modport slave (
    input  req_valid, req_addr, req_wr_data, req_wr_ena, req_access, req_lock,
    input  mem_rd_data, mem_exception,
    output req_ready, resp_valid, resp_rd_data, resp_exception,
    output mem_addr, mem_wr_data, mem_wr_ena, mem_access
  );

  modport master (
    output req_valid, req_addr, req_wr_data, req_wr_ena, req_access, req_lock,
    output mem_rd_data, mem_exception,
    input  req_ready, resp_valid, resp_rd_data, resp_exception,
    input  mem_addr, mem_wr_data, mem_wr_ena, mem_access
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker. Scans from i_last_grant+1 (mod NUM_REQ)
// and selects the first requester that is both requesting and unmasked.
//   i_req        : request vector
//   i_mask       : eligibility vector (1 = may be granted)
//   i_last_grant : index of the previous winner
//   o_grant      : one-hot winner
//   o_grant_idx  : binary winner index
//   o_any        : a winner exists
// -----------------------------------------------------------------------------
module rr_priority_picker #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_idx;

  // NOTE: every output of a combinational block gets a default at the top, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = '0;
    // Offset 1 first: the previous winner is considered last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
      if (!o_any && i_req[w_idx] && i_mask[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one single-port memory among NUM_REQ requesters with round-robin
// arbitration, a valid/ready request and a one-cycle response pulse.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : mem_bus_arbiter_if.slave (requester handshake + memory port)
// Flow: S_IDLE -> S_ACCESS -> S_RESPOND -> (S_ACCESS | S_IDLE).
// Accept at t, memory sees the address at t+1, response pulse at t+2.
// Optional feature macro: ARB_BUS_LOCK_EN (bus lock for atomic RMW).
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  typedef logic [IDX_W-1:0] idx_t;

  if (NUM_REQ < 2 || NUM_REQ > MEM_ARB_MAX_REQ) begin : g_num_req_check
    $error("mem_bus_arbiter: NUM_REQ must be in 2..MEM_ARB_MAX_REQ");
  end

  arb_state_t         r_state;
  arb_state_t         w_next_state;
  idx_t               r_last_grant;
  idx_t               r_hold_idx;
  logic [31:0]        r_hold_addr;
  logic [31:0]        r_hold_wr_data;
  logic               r_hold_wr_ena;
  mem_access_t        r_hold_access;

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_grant;
  idx_t               w_grant_idx;
  logic               w_any;
  logic               w_arb_point;
  logic               w_accept;

  // The bus is free to take a new request while idle and while the previous
  // response is on its way out.
  assign w_arb_point = (r_state == S_IDLE) || (r_state == S_RESPOND);
  assign w_accept    = w_arb_point && w_any;

`ifdef ARB_BUS_LOCK_EN
  logic r_locked;
  idx_t r_lock_owner;
  logic w_owner_holds;

  // The owner keeps the bus while it is still asking for it (a pending
  // request, even one that will drop the lock) or still holds req_lock.
  // Only when it does neither is the bus reopened to everybody.
  assign w_owner_holds = bus.req_valid[r_lock_owner] || bus.req_lock[r_lock_owner];

  always_comb begin
    w_mask = '1;
    if (r_locked && w_owner_holds) begin
      w_mask               = '0;
      w_mask[r_lock_owner] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked     <= 1'b0;
      r_lock_owner <= '0;
    end else if (w_accept) begin
      // While locked only the owner can be accepted, so this both takes and
      // releases the lock.
      r_locked <= bus.req_lock[w_grant_idx];
      if (bus.req_lock[w_grant_idx]) begin
        r_lock_owner <= w_grant_idx;
      end
    end else if (w_arb_point && r_locked && !w_owner_holds) begin
      r_locked <= 1'b0;
    end
  end
`else
  logic w_unused_lock;

  assign w_mask        = '1;
  assign w_unused_lock = ^bus.req_lock;
`endif

  rr_priority_picker #(
    .NUM_REQ      (NUM_REQ)
  ) u_picker (
    .i_req        (bus.req_valid),
    .i_mask       (w_mask),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_any        (w_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    w_next_state = w_accept ? S_ACCESS : S_IDLE;
      S_ACCESS:  w_next_state = S_RESPOND;
      S_RESPOND: w_next_state = w_accept ? S_ACCESS : S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Index NUM_REQ-1 so requester 0 wins the first arbitration.
      r_last_grant   <= idx_t'(NUM_REQ - 1);
      r_hold_idx     <= '0;
      r_hold_addr    <= '0;
      r_hold_wr_data <= '0;
      r_hold_wr_ena  <= 1'b0;
      r_hold_access  <= MEM_ACCESS_BYTE;
    end else if (w_accept) begin
      r_last_grant   <= w_grant_idx;
      r_hold_idx     <= w_grant_idx;
      r_hold_addr    <= bus.req_addr[w_grant_idx];
      r_hold_wr_data <= bus.req_wr_data[w_grant_idx];
      r_hold_wr_ena  <= bus.req_wr_ena[w_grant_idx];
      r_hold_access  <= bus.req_access[w_grant_idx];
    end
  end

  always_comb begin
    bus.req_ready      = '0;
    bus.resp_valid     = '0;
    bus.resp_rd_data   = '0;
    bus.resp_exception = MEM_EXC_NONE;
    bus.mem_addr       = MEM_ADDR_IDLE;
    bus.mem_wr_data    = MEM_DATA_IDLE;
    bus.mem_wr_ena     = 1'b0;
    bus.mem_access     = MEM_ACCESS_IDLE;

    if (w_accept) begin
      bus.req_ready = w_grant;
    end

    case (r_state)
      S_ACCESS: begin
        bus.mem_addr    = r_hold_addr;
        bus.mem_wr_data = r_hold_wr_data;
        bus.mem_wr_ena  = r_hold_wr_ena;
        bus.mem_access  = r_hold_access;
      end
      S_RESPOND: begin
        // Address stays up for the synchronous read; the strobe does not, so a
        // store is written exactly once.
        bus.mem_addr               = r_hold_addr;
        bus.mem_wr_data            = r_hold_wr_data;
        bus.mem_access             = r_hold_access;
        bus.resp_valid[r_hold_idx] = 1'b1;
        bus.resp_rd_data           = bus.mem_rd_data;
        bus.resp_exception         = bus.mem_exception;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed, table-driven bench for mem_bus_arbiter (NUM_REQ = 2) with a small
// synchronous-read memory model. Each table row is one clock cycle: inputs
// driven after the falling edge, outputs compared 1 ns later.
// Optional feature macro: ARB_BUS_LOCK_EN selects the lock sequence.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int NUM_REQ = 2;

  localparam logic [31:0] A4 = 32'h1000_0004;
  localparam logic [31:0] A8 = 32'h1000_0008;
  localparam logic [31:0] AC = 32'h1000_000C;
  localparam logic [31:0] AS = 32'h2000_0000;
  localparam logic [31:0] AU = 32'hF000_0000;
  localparam mem_access_t W  = MEM_ACCESS_WORD;
  localparam mem_access_t B  = MEM_ACCESS_BYTE;
  localparam mem_exception_mask_t XF = MEM_EXC_ACCESS_FAULT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  mem_bus_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: registered read (read-before-write), unmapped >= 0xF000_0000.
  logic [31:0] mem_model [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    bus.mem_rd_data   <= mem_read(bus.mem_addr);
    bus.mem_exception <= (bus.mem_addr >= AU) ? XF : MEM_EXC_NONE;
    if (bus.mem_wr_ena) mem_model[bus.mem_addr] = bus.mem_wr_data;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] valid, input logic [1:0] wr, input logic [1:0] lock,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] wd0, input logic [31:0] wd1);
    bus.req_valid      = valid;
    bus.req_wr_ena     = wr;
    bus.req_lock       = lock;
    bus.req_addr[0]    = a0;
    bus.req_addr[1]    = a1;
    bus.req_wr_data[0] = wd0;
    bus.req_wr_data[1] = wd1;
    bus.req_access[0]  = W;
    bus.req_access[1]  = B;
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] er, input logic [1:0] ersp,
                               input logic [31:0] ea, input logic [31:0] ewd, input logic ewr,
                               input mem_access_t eacc, input logic [31:0] erd,
                               input mem_exception_mask_t eexc);
    check({tag, ".req_ready"},      32'(bus.req_ready),      32'(er));
    check({tag, ".resp_valid"},     32'(bus.resp_valid),     32'(ersp));
    check({tag, ".mem_addr"},       bus.mem_addr,            ea);
    check({tag, ".mem_wr_data"},    bus.mem_wr_data,         ewd);
    check({tag, ".mem_wr_ena"},     32'(bus.mem_wr_ena),     32'(ewr));
    check({tag, ".mem_access"},     32'(bus.mem_access),     32'(eacc));
    check({tag, ".resp_rd_data"},   bus.resp_rd_data,        erd);
    check({tag, ".resp_exception"}, 32'(bus.resp_exception), 32'(eexc));
  endtask

  typedef struct {
    logic [1:0]          valid;
    logic [1:0]          wr;
    logic [31:0]         a0, a1, wd0, wd1;
    logic [1:0]          er, ersp;
    logic [31:0]         ea, ewd;
    logic                ewr;
    mem_access_t         eacc;
    logic [31:0]         erd;
    mem_exception_mask_t eexc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] wr,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] wd0, input logic [31:0] wd1,
                              input logic [1:0] er, input logic [1:0] ersp,
                              input logic [31:0] ea, input logic [31:0] ewd, input logic ewr,
                              input mem_access_t eacc, input logic [31:0] erd,
                              input mem_exception_mask_t eexc);
    vec_t v;
    v.valid = valid; v.wr = wr; v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1;
    v.er = er; v.ersp = ersp; v.ea = ea; v.ewd = ewd; v.ewr = ewr;
    v.eacc = eacc; v.erd = erd; v.eexc = eexc;
    return v;
  endfunction

  initial begin
    mem_model[A4] = 32'hDEAD_BEEF;
    mem_model[A8] = 32'h1111_1111;
    mem_model[AC] = 32'h2222_2222;

    //            valid  wr     a0  a1  wd0 wd1    | ready  resp   mem_addr wdata wr  acc rd_data       exc
    // Single load from port 0.
    vecs.push_back(mk(2'b01, 2'b00, A4, 0,  0, 0,     2'b01, 2'b00, 0,  0, 0, W, 0,             0));
    vecs.push_back(mk(2'b00, 2'b00, A4, 0,  0, 0,     2'b00, 2'b00, A4, 0, 0, W, 0,             0));
    vecs.push_back(mk(2'b00, 2'b00, A4, 0,  0, 0,     2'b00, 2'b01, A4, 0, 0, W, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0,  0,  0, 0,     2'b00, 2'b00, 0,  0, 0, W, 0,             0));
    // Both ports continuously valid: strict alternation, port 1 first.
    vecs.push_back(mk(2'b11, 2'b00, A8, AC, 0, 0,     2'b10, 2'b00, 0,  0, 0, W, 0,             0));
    vecs.push_back(mk(2'b11, 2'b00, A8, AC, 0, 0,     2'b00, 2'b00, AC, 0, 0, B, 0,             0));
    vecs.push_back(mk(2'b11, 2'b00, A8, AC, 0, 0,     2'b01, 2'b10, AC, 0, 0, B, 32'h2222_2222, 0));
    vecs.push_back(mk(2'b11, 2'b00, A8, AC, 0, 0,     2'b00, 2'b00, A8, 0, 0, W, 0,             0));
    vecs.push_back(mk(2'b11, 2'b00, A8, AC, 0, 0,     2'b10, 2'b01, A8, 0, 0, W, 32'h1111_1111, 0));
    vecs.push_back(mk(2'b11, 2'b00, A8, AC, 0, 0,     2'b00, 2'b00, AC, 0, 0, B, 0,             0));
    vecs.push_back(mk(2'b11, 2'b00, A8, AC, 0, 0,     2'b01, 2'b10, AC, 0, 0, B, 32'h2222_2222, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0,  0,  0, 0,     2'b00, 2'b00, A8, 0, 0, W, 0,             0));
    vecs.push_back(mk(2'b00, 2'b00, 0,  0,  0, 0,     2'b00, 2'b01, A8, 0, 0, W, 32'h1111_1111, 0));
    // Port 1 stores 0x55, port 0 reads it back.
    vecs.push_back(mk(2'b10, 2'b10, 0,  AS, 0, 32'h55, 2'b10, 2'b00, 0, 0,      0, W, 0,        0));
    vecs.push_back(mk(2'b00, 2'b10, 0,  AS, 0, 32'h55, 2'b00, 2'b00, AS, 32'h55, 1, B, 0,       0));
    vecs.push_back(mk(2'b01, 2'b00, AS, 0,  0, 0,     2'b01, 2'b10, AS, 32'h55, 0, B, 0,        0));
    vecs.push_back(mk(2'b00, 2'b00, 0,  0,  0, 0,     2'b00, 2'b00, AS, 0, 0, W, 0,             0));
    vecs.push_back(mk(2'b00, 2'b00, 0,  0,  0, 0,     2'b00, 2'b01, AS, 0, 0, W, 32'h55,        0));
    // Unmapped access, then a normal back-to-back request from the same port.
    vecs.push_back(mk(2'b01, 2'b00, AU, 0,  0, 0,     2'b01, 2'b00, 0,  0, 0, W, 0,             0));
    vecs.push_back(mk(2'b00, 2'b00, AU, 0,  0, 0,     2'b00, 2'b00, AU, 0, 0, W, 0,             0));
    vecs.push_back(mk(2'b01, 2'b00, A4, 0,  0, 0,     2'b01, 2'b01, AU, 0, 0, W, 0,             XF));
    vecs.push_back(mk(2'b00, 2'b00, 0,  0,  0, 0,     2'b00, 2'b00, A4, 0, 0, W, 0,             0));
    vecs.push_back(mk(2'b00, 2'b00, 0,  0,  0, 0,     2'b00, 2'b01, A4, 0, 0, W, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0,  0,  0, 0,     2'b00, 2'b00, 0,  0, 0, W, 0,             0));

    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_outputs("in_reset", 2'b00, 2'b00, 0, 0, 0, W, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_outputs("after_reset", 2'b00, 2'b00, 0, 0, 0, W, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].wr, 2'b00, vecs[i].a0, vecs[i].a1, vecs[i].wd0, vecs[i].wd1);
      #1 check_outputs($sformatf("vec%0d", i), vecs[i].er, vecs[i].ersp, vecs[i].ea, vecs[i].ewd,
                       vecs[i].ewr, vecs[i].eacc, vecs[i].erd, vecs[i].eexc);
    end

    // Asynchronous reset in the middle of a port 0 load. Before the reset the
    // last grant was port 0, so a port 0 win afterwards proves the pointer reset.
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b00, A4, 0, 0, 0);
    #1 check_outputs("rst_mid.accept", 2'b01, 2'b00, 0, 0, 0, W, 0, 0);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    #1 check_outputs("rst_mid.access", 2'b00, 2'b00, A4, 0, 0, W, 0, 0);
    #2 rst = 1'b1;
    #1 check_outputs("rst_mid.async", 2'b00, 2'b00, 0, 0, 0, W, 0, 0);
    @(negedge clk);
    #1 check_outputs("rst_mid.held", 2'b00, 2'b00, 0, 0, 0, W, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b11, 2'b00, 2'b00, A4, AC, 0, 0);
    #1 check_outputs("rst_mid.regrant", 2'b01, 2'b00, 0, 0, 0, W, 0, 0);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    #1 check_outputs("rst_mid.access2", 2'b00, 2'b00, A4, 0, 0, W, 0, 0);
    @(negedge clk);
    #1 check_outputs("rst_mid.resp", 2'b00, 2'b01, A4, 0, 0, W, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    #1 check_outputs("rst_mid.idle", 2'b00, 2'b00, 0, 0, 0, W, 0, 0);

    // Locked read-modify-write from port 0 with port 1 competing.
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b01, A4, AC, 0, 0);
    #1 check_outputs("lock.n0", 2'b01, 2'b00, 0, 0, 0, W, 0, 0);
    @(negedge clk);
    drive(2'b11, 2'b01, 2'b00, A8, AC, 32'h77, 0);
    #1 check_outputs("lock.n1", 2'b00, 2'b00, A4, 0, 0, W, 0, 0);
`ifdef ARB_BUS_LOCK_EN
    @(negedge clk);
    #1 check_outputs("lock.n2", 2'b01, 2'b01, A4, 0, 0, W, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    drive(2'b10, 2'b00, 2'b00, 0, AC, 0, 0);
    #1 check_outputs("lock.n3", 2'b00, 2'b00, A8, 32'h77, 1, W, 0, 0);
    @(negedge clk);
    #1 check_outputs("lock.n4", 2'b10, 2'b01, A8, 32'h77, 0, W, 32'h1111_1111, 0);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    #1 check_outputs("lock.n5", 2'b00, 2'b00, AC, 0, 0, B, 0, 0);
    @(negedge clk);
    #1 check_outputs("lock.n6", 2'b00, 2'b10, AC, 0, 0, B, 32'h2222_2222, 0);
`else
    @(negedge clk);
    #1 check_outputs("nolock.n2", 2'b10, 2'b01, A4, 0, 0, W, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    drive(2'b01, 2'b01, 2'b00, A8, 0, 32'h77, 0);
    #1 check_outputs("nolock.n3", 2'b00, 2'b00, AC, 0, 0, B, 0, 0);
    @(negedge clk);
    #1 check_outputs("nolock.n4", 2'b01, 2'b10, AC, 0, 0, B, 32'h2222_2222, 0);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    #1 check_outputs("nolock.n5", 2'b00, 2'b00, A8, 32'h77, 1, W, 0, 0);
    @(negedge clk);
    #1 check_outputs("nolock.n6", 2'b00, 2'b01, A8, 32'h77, 0, W, 32'h1111_1111, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
